temp_display_scan: RTL and testbench

Three-digit multiplexed 7-segment scan driver sitting directly downstream of the LM07 SPI reader and its binary-to-BCD stage. Latches the sign bit and two BCD digits on a one-cycle valid strobe, then time-multiplexes them onto one shared active-low segment bus with active-low digit enables. Handles leading-zero blanking, invalid-BCD indication, anti-ghosting guard time and a stale-data timeout that shows "---".

---
 rtl/temp_display_scan.sv | 144 ++++++++++++++
 tb/tb_temp_display_scan.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/temp_display_scan.sv
// temp_display_scan: three-digit multiplexed 7-segment scan driver
// for the LM07 sign/BCD sample, with blanking, guard and stale dash.
module temp_display_scan #(
  parameter int          REFRESH_DIV  = 1000,
  parameter int          GUARD        = 2,
  parameter logic [23:0] STALE_CYCLES = 24'd5_000_000
) (
  input  logic       SYSCLK,
  input  logic       RST,
  input  logic       data_valid,
  input  logic       temp_sign,
  input  logic [3:0] bcd_tens,
  input  logic [3:0] bcd_ones,
  output logic [6:0] SEG,
  output logic [2:0] DIG_SEL,
  output logic       stale
);

  typedef enum logic [1:0] {
    S_SIGN = 2'd0,
    S_TENS = 2'd1,
    S_ONES = 2'd2
  } slot_t;

  localparam logic [15:0] DIV_LAST = 16'(REFRESH_DIV - 1);
  localparam logic [15:0] GUARD_W  = 16'(GUARD);
  localparam logic [6:0]  G_DASH   = 7'b0111111;
  localparam logic [6:0]  G_BLANK  = 7'b1111111;

  logic [15:0] presc;
  slot_t       slot;
  logic        sign_r;
  logic [3:0]  tens_r;
  logic [3:0]  ones_r;
  logic [23:0] stale_cnt;
  logic [6:0]  glyph;
  logic [2:0]  dig_nxt;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = G_DASH;
    endcase
    return s;
  endfunction

  // Slot prescaler and slot sequencer; slot advances on the last prescaler count
  always_ff @(posedge SYSCLK or posedge RST) begin
    if (RST) begin
      presc <= '0;
      slot  <= S_SIGN;
    end else if (presc == DIV_LAST) begin
      presc <= '0;
      case (slot)
        S_SIGN:  slot <= S_TENS;
        S_TENS:  slot <= S_ONES;
        S_ONES:  slot <= S_SIGN;
        default: slot <= S_SIGN;
      endcase
    end else begin
      presc <= presc + 16'd1;
    end
  end

  // Sample latch plus stale watchdog; a fresh sample beats the terminal count
  always_ff @(posedge SYSCLK or posedge RST) begin
    if (RST) begin
      sign_r    <= 1'b0;
      tens_r    <= '0;
      ones_r    <= '0;
      stale_cnt <= '0;
      stale     <= 1'b1;
    end else if (data_valid) begin
      sign_r    <= temp_sign;
      tens_r    <= bcd_tens;
      ones_r    <= bcd_ones;
      stale_cnt <= '0;
      stale     <= 1'b0;
    end else if (stale_cnt < STALE_CYCLES) begin
      stale_cnt <= stale_cnt + 24'd1;
      if (stale_cnt == STALE_CYCLES - 24'd1)
        stale <= 1'b1;
    end
  end

  // Glyph for the current slot, stale dash overriding everything
  always_comb begin
    glyph = G_BLANK;
    if (stale) begin
      glyph = G_DASH;
    end else begin
      case (slot)
        S_SIGN:
          glyph = sign_r ? G_DASH : G_BLANK;
        S_TENS:
          if (tens_r > 4'd9)
            glyph = G_DASH;
          else if (tens_r == 4'd0)
            glyph = G_BLANK;
          else
            glyph = seg7(tens_r);
        S_ONES:
          glyph = (ones_r > 4'd9) ? G_DASH : seg7(ones_r);
        default:
          glyph = G_BLANK;
      endcase
    end
  end

  // Digit enable: dark during the guard window at the head of each slot
  always_comb begin
    dig_nxt = 3'b111;
    if (presc >= GUARD_W) begin
      case (slot)
        S_SIGN:  dig_nxt = 3'b011;
        S_TENS:  dig_nxt = 3'b101;
        S_ONES:  dig_nxt = 3'b110;
        default: dig_nxt = 3'b111;
      endcase
    end
  end

  // Registered segment and digit outputs
  always_ff @(posedge SYSCLK or posedge RST) begin
    if (RST) begin
      SEG     <= G_BLANK;
      DIG_SEL <= 3'b111;
    end else begin
      SEG     <= glyph;
      DIG_SEL <= dig_nxt;
    end
  end

endmodule

// File: tb/tb_temp_display_scan.sv
// tb_temp_display_scan: directed table-driven bench for the scan driver
// with REFRESH_DIV=8, GUARD=2, STALE_CYCLES=20.
module tb_temp_display_scan;

  logic       SYSCLK = 1'b0;
  logic       RST = 1'b1;
  logic       data_valid = 1'b0;
  logic       temp_sign = 1'b0;
  logic [3:0] bcd_tens = '0;
  logic [3:0] bcd_ones = '0;
  logic [6:0] SEG;
  logic [2:0] DIG_SEL;
  logic       stale;

  int ncmp = 0;
  int nerr = 0;

  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;

  temp_display_scan #(
    .REFRESH_DIV (8),
    .GUARD       (2),
    .STALE_CYCLES(24'd20)
  ) dut (
    .SYSCLK    (SYSCLK),
    .RST       (RST),
    .data_valid(data_valid),
    .temp_sign (temp_sign),
    .bcd_tens  (bcd_tens),
    .bcd_ones  (bcd_ones),
    .SEG       (SEG),
    .DIG_SEL   (DIG_SEL),
    .stale     (stale)
  );

  always #5 SYSCLK = ~SYSCLK;

  typedef struct {
    logic       sgn;
    logic [3:0] tens;
    logic [3:0] ones;
    logic [6:0] e_sign;
    logic [6:0] e_tens;
    logic [6:0] e_ones;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [6:0] act,
                     input logic [6:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic wait_dig(input logic [2:0] t, input string nm);
    int n = 0;
    while (DIG_SEL !== t && n < 40) begin
      @(negedge SYSCLK);
      n++;
    end
    if (DIG_SEL !== t) begin
      ncmp++;
      nerr++;
      $display("FAIL %s: timeout DIG_SEL=%b want %b", nm, DIG_SEL, t);
    end
  endtask

  task automatic pulse_valid();
    data_valid = 1'b1;
    @(negedge SYSCLK);
    data_valid = 1'b0;
  endtask

  initial begin
    vecs[0] = '{1'b0, 4'd2, 4'd5, BLANK, 7'b0100100, 7'b0010010};
    vecs[1] = '{1'b1, 4'd0, 4'd7, DASH, BLANK, 7'b1111000};
    vecs[2] = '{1'b0, 4'hA, 4'd3, BLANK, DASH, 7'b0110000};
    vecs[3] = '{1'b1, 4'd9, 4'hB, DASH, 7'b0010000, DASH};
    vecs[4] = '{1'b0, 4'd0, 4'd0, BLANK, BLANK, 7'b1000000};
    vecs[5] = '{1'b0, 4'd8, 4'd6, BLANK, 7'b0000000, 7'b0000010};

    // reset state
    repeat (2) @(negedge SYSCLK);
    chk("rst_seg", SEG, BLANK);
    chk("rst_dig", {4'd0, DIG_SEL}, 7'b0000111);
    chk("rst_stale", {6'd0, stale}, 7'd1);
    RST = 1'b0;
    @(negedge SYSCLK);
    chk("rel_dig1", {4'd0, DIG_SEL}, 7'b0000111);
    @(negedge SYSCLK);
    chk("rel_dig2", {4'd0, DIG_SEL}, 7'b0000111);
    @(negedge SYSCLK);
    chk("rel_dig3", {4'd0, DIG_SEL}, 7'b0000011);
    chk("rel_seg3", SEG, DASH);

    // table: data_valid held so the 20-cycle watchdog never fires
    for (int i = 0; i < 6; i++) begin
      temp_sign  = vecs[i].sgn;
      bcd_tens   = vecs[i].tens;
      bcd_ones   = vecs[i].ones;
      data_valid = 1'b1;
      repeat (3) @(negedge SYSCLK);
      chk($sformatf("v%0d_stale", i), {6'd0, stale}, 7'd0);
      wait_dig(3'b011, $sformatf("v%0d_wsign", i));
      chk($sformatf("v%0d_sign", i), SEG, vecs[i].e_sign);
      wait_dig(3'b101, $sformatf("v%0d_wtens", i));
      chk($sformatf("v%0d_tens", i), SEG, vecs[i].e_tens);
      wait_dig(3'b110, $sformatf("v%0d_wones", i));
      chk($sformatf("v%0d_ones", i), SEG, vecs[i].e_ones);
    end
    data_valid = 1'b0;

    // stale timeout: 20 cycles after the strobe
    temp_sign = 1'b0;
    bcd_tens  = 4'd2;
    bcd_ones  = 4'd5;
    pulse_valid();
    chk("st_clr", {6'd0, stale}, 7'd0);
    repeat (19) @(negedge SYSCLK);
    chk("st_19", {6'd0, stale}, 7'd0);
    @(negedge SYSCLK);
    chk("st_20", {6'd0, stale}, 7'd1);
    wait_dig(3'b011, "st_wsign");
    chk("st_sign", SEG, DASH);
    wait_dig(3'b101, "st_wtens");
    chk("st_tens", SEG, DASH);
    wait_dig(3'b110, "st_wones");
    chk("st_ones", SEG, DASH);
    pulse_valid();
    chk("st_recov", {6'd0, stale}, 7'd0);
    @(negedge SYSCLK);
    chk("st_rdig", {4'd0, DIG_SEL}, 7'b0000110);
    chk("st_rseg", SEG, 7'b0010010);

    // strobe coincident with terminal count: strobe wins
    pulse_valid();
    repeat (19) @(negedge SYSCLK);
    chk("tc_19", {6'd0, stale}, 7'd0);
    pulse_valid();
    chk("tc_win", {6'd0, stale}, 7'd0);

    // strobe coincident with a slot wrap (tens -> ones)
    data_valid = 1'b1;
    wait_dig(3'b101, "wr_wtens");
    data_valid = 1'b0;
    repeat (4) @(negedge SYSCLK);
    bcd_ones = 4'd3;
    pulse_valid();
    chk("wr_tail", {4'd0, DIG_SEL}, 7'b0000101);
    chk("wr_tseg", SEG, 7'b0100100);
    @(negedge SYSCLK);
    chk("wr_g0", {4'd0, DIG_SEL}, 7'b0000111);
    @(negedge SYSCLK);
    chk("wr_g1", {4'd0, DIG_SEL}, 7'b0000111);
    @(negedge SYSCLK);
    chk("wr_dig", {4'd0, DIG_SEL}, 7'b0000110);
    chk("wr_seg", SEG, 7'b0110000);

    // reset mid-slot
    #2 RST = 1'b1;
    #1;
    chk("mr_seg", SEG, BLANK);
    chk("mr_dig", {4'd0, DIG_SEL}, 7'b0000111);
    chk("mr_stale", {6'd0, stale}, 7'd1);
    @(negedge SYSCLK);
    RST = 1'b0;
    repeat (2) @(negedge SYSCLK);
    chk("mr_g", {4'd0, DIG_SEL}, 7'b0000111);
    @(negedge SYSCLK);
    chk("mr_dig3", {4'd0, DIG_SEL}, 7'b0000011);
    chk("mr_seg3", SEG, DASH);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
